// File: rtl/eeg_load_ctrl_pkg.sv
// Shared types and constants for the EEG front-end: ADC sample, intermediate-result
// memory words and addresses, memory map and the epoch-load FSM states.
package eeg_load_ctrl_pkg;

    localparam int NUM_PATCHES          = 60;
    localparam int PATCH_LEN            = 64;
    localparam int ADC_BITWIDTH         = 16;
    localparam int Q_STO_INT_RES_DOUBLE = 20;
    localparam int INT_RES_DOUBLE_W     = 30;
    localparam int INT_RES_ADDR_W       = 16;

    typedef logic [ADC_BITWIDTH-1:0]     AdcData_t;
    typedef logic [INT_RES_ADDR_W-1:0]   IntResAddr_t;
    typedef logic [INT_RES_DOUBLE_W-1:0] IntResDouble_t;

    typedef enum logic {
        SINGLE_WIDTH = 1'b0,
        DOUBLE_WIDTH = 1'b1
    } DataWidth_t;

    typedef enum logic [2:0] {
        INT_RES_SW_FX = 3'd0,
        INT_RES_DW_FX = 3'd1,
        INT_RES_SW_FX_SOFTMAX = 3'd2,
        INT_RES_DW_FX_SOFTMAX = 3'd3
    } FxFormatIntRes_t;

    // Regions of intermediate-result memory; EEG samples occupy the first epoch-sized block
    typedef enum logic [1:0] {
        EEG_INPUT_MEM   = 2'd0,
        PATCH_MEM       = 2'd1,
        CLASS_TOKEN_MEM = 2'd2,
        POS_EMB_MEM     = 2'd3
    } IntResMem_t;

    localparam IntResAddr_t mem_map [4] = '{16'd0, 16'd3840, 16'd7680, 16'd7744};

    typedef enum logic [1:0] {
        IDLE_EEG = 2'd0,
        LOAD_EEG = 2'd1,
        DONE_EEG = 2'd2
    } EegLoadState_t;

endpackage

// File: rtl/eeg_load_ctrl_adc_to_fx.sv
// Unsigned ADC sample to double-width intermediate-result fixed point.
// The sample lands in the fractional field, so the result is sample/2^ADC_BITWIDTH.
module adc_to_fx
    import eeg_load_ctrl_pkg::*;
#(
    parameter int FRAC_SHIFT = Q_STO_INT_RES_DOUBLE - ADC_BITWIDTH
) (
    input  AdcData_t      sample,
    output IntResDouble_t fx
);

    assign fx = IntResDouble_t'(sample) << FRAC_SHIFT;

endmodule

// File: rtl/eeg_load_ctrl.sv
// EEG epoch loader: converts a stream of ADC samples and writes one epoch contiguously
// into intermediate-result memory through a one-entry stall buffer.
module eeg_load_ctrl
    import eeg_load_ctrl_pkg::*;
#(
    parameter int          NUM_SAMPLES = NUM_PATCHES * PATCH_LEN,
    parameter IntResAddr_t BASE_ADDR   = mem_map[EEG_INPUT_MEM],
    parameter int          FRAC_SHIFT  = Q_STO_INT_RES_DOUBLE - ADC_BITWIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            sample_valid,
    input  AdcData_t        sample_data,
    output logic            mem_wr_en,
    output IntResAddr_t     mem_wr_addr,
    output IntResDouble_t   mem_wr_data,
    output DataWidth_t      mem_wr_width,
    output FxFormatIntRes_t mem_wr_format,
    input  logic            mem_wr_grant,
    output logic            busy,
    output logic            done,
    output logic            overrun,
    output logic [11:0]     sample_count
);

    localparam logic [11:0] LAST_IDX = 12'(NUM_SAMPLES - 1);

    EegLoadState_t state_q, state_d;
    IntResDouble_t fx_p0;
    logic          wr_fire, last_wr, capture, drop;

    adc_to_fx #(
        .FRAC_SHIFT(FRAC_SHIFT)
    ) u_adc_to_fx (
        .sample(sample_data),
        .fx    (fx_p0)
    );

    assign mem_wr_width  = DOUBLE_WIDTH;
    assign mem_wr_format = INT_RES_DW_FX;

    // mem_wr_en doubles as the buffer-full flag: a held sample is always being offered
    always_comb begin
        wr_fire = (state_q == LOAD_EEG) && mem_wr_en && mem_wr_grant;
        last_wr = wr_fire && (sample_count == LAST_IDX);
        capture = (state_q == LOAD_EEG) && sample_valid && !last_wr
                  && (!mem_wr_en || mem_wr_grant);
        drop    = (state_q == LOAD_EEG) && sample_valid && mem_wr_en && !mem_wr_grant;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE_EEG: if (start) state_d = LOAD_EEG;
            LOAD_EEG: begin
                busy = 1'b1;
                if (last_wr) state_d = DONE_EEG;
            end
            DONE_EEG: begin
                done    = 1'b1;
                state_d = IDLE_EEG;
            end
            default: state_d = IDLE_EEG;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE_EEG;
            mem_wr_en    <= 1'b0;
            mem_wr_addr  <= BASE_ADDR;
            mem_wr_data  <= '0;
            overrun      <= 1'b0;
            sample_count <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE_EEG) && start) begin
                mem_wr_addr  <= BASE_ADDR;
                sample_count <= '0;
                overrun      <= 1'b0;
            end
            // Address stops on the last slot so it never leaves the epoch region
            if (wr_fire) begin
                sample_count <= sample_count + 12'd1;
                if (!last_wr) mem_wr_addr <= mem_wr_addr + IntResAddr_t'(1);
            end
            if (capture) begin
                mem_wr_en   <= 1'b1;
                mem_wr_data <= fx_p0;
            end else if (wr_fire) begin
                mem_wr_en <= 1'b0;
            end
            if (drop) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_eeg_load_ctrl.sv
// Bench for eeg_load_ctrl: directed scenarios plus a randomized epoch checked against
// a transaction-level reference model of the loader.
module tb_eeg_load_ctrl;
    import eeg_load_ctrl_pkg::*;

    localparam int NUM = 3840;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic        mem_wr_grant = 1'b0;
    logic        mem_wr_en;
    logic [15:0] mem_wr_addr;
    logic [29:0] mem_wr_data;
    logic        mem_wr_width;
    logic [2:0]  mem_wr_format;
    logic        busy, done, overrun;
    logic [11:0] sample_count;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit          m_busy, m_pend, m_ovr, m_done;
    int          m_cnt, m_addr;
    logic [29:0] m_data;

    eeg_load_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_width (mem_wr_width),
        .mem_wr_format(mem_wr_format),
        .mem_wr_grant (mem_wr_grant),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_busy = 0; m_pend = 0; m_ovr = 0; m_done = 0;
        m_cnt = 0; m_addr = 0; m_data = '0;
    endtask

    // One clock: drive inputs, advance to the edge, update the model, settle 1 time unit
    task automatic tick(input logic st, input logic sv, input logic [15:0] sd, input logic gr);
        bit fire, fin;
        start = st; sample_valid = sv; sample_data = sd; mem_wr_grant = gr;
        @(posedge clk);
        if (m_done) begin
            m_done = 0;
        end else if (!m_busy) begin
            if (st) begin
                m_busy = 1; m_cnt = 0; m_ovr = 0; m_addr = 0; m_pend = 0;
            end
        end else begin
            fire = m_pend && gr;
            fin  = fire && (m_cnt == NUM - 1);
            if (fire) begin
                m_pend = 0;
                m_cnt++;
                if (!fin) m_addr++;
            end
            if (fin) begin
                m_busy = 0;
                m_done = 1;
            end else if (sv) begin
                if (!m_pend) begin
                    m_pend = 1;
                    m_data = 30'(sd) * 30'd16;
                end else begin
                    m_ovr = 1;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        start = 0; sample_valid = 0; mem_wr_grant = 0; sample_data = '0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        #2 rst = 1;
        #2;
        checks++;
        if (mem_wr_en !== 1'b0 || mem_wr_addr !== 16'd0 || mem_wr_data !== 30'd0) begin
            errors++;
            $display("FAIL reset_mem: got en=%b addr=%0h data=%0h, expected en=0 addr=0 data=0",
                     mem_wr_en, mem_wr_addr, mem_wr_data);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0 || sample_count !== 12'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b done=%b ovr=%b cnt=%0d, expected 0 0 0 0",
                     busy, done, overrun, sample_count);
        end
        checks++;
        if (mem_wr_width !== DOUBLE_WIDTH || mem_wr_format !== INT_RES_DW_FX) begin
            errors++;
            $display("FAIL reset_fmt: got width=%b format=%0d, expected 1 and 1",
                     mem_wr_width, mem_wr_format);
        end
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic test_full_epoch();
        int dones = 0;
        tick(1, 0, 16'd0, 0);
        checks++;
        if (busy !== 1'b1 || mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL epoch_start: got busy=%b en=%b, expected busy=1 en=0", busy, mem_wr_en);
        end
        for (int k = 0; k < NUM; k++) begin
            tick(0, 1, 16'(k), 1);
            if (done === 1'b1) dones++;
            checks++;
            if (mem_wr_en !== 1'b1 || mem_wr_addr !== 16'(k) || mem_wr_data !== (30'(k) << 4)
                || sample_count !== 12'(k)) begin
                errors++;
                $display("FAIL epoch_write[%0d]: got en=%b addr=%0d data=%0h cnt=%0d, expected en=1 addr=%0d data=%0h cnt=%0d",
                         k, mem_wr_en, mem_wr_addr, mem_wr_data, sample_count, k, 30'(k) << 4, k);
            end
        end
        // a sample arriving with the final grant is dropped silently
        tick(0, 1, 16'hAAAA, 1);
        if (done === 1'b1) dones++;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || mem_wr_en !== 1'b0 || overrun !== 1'b0
            || sample_count !== 12'd3840) begin
            errors++;
            $display("FAIL epoch_done: got done=%b busy=%b en=%b ovr=%b cnt=%0d, expected 1 0 0 0 3840",
                     done, busy, mem_wr_en, overrun, sample_count);
        end
        tick(0, 0, 16'd0, 0);
        if (done === 1'b1) dones++;
        checks++;
        if (dones != 1 || busy !== 1'b0 || mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL epoch_done_once: got done pulses=%0d busy=%b en=%b, expected 1 pulse busy=0 en=0",
                     dones, busy, mem_wr_en);
        end
    endtask

    task automatic test_idle_ignore();
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 16'($urandom), 1);
            checks++;
            if (mem_wr_en !== 1'b0 || sample_count !== 12'd3840 || overrun !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignore[%0d]: got en=%b cnt=%0d ovr=%b busy=%b, expected en=0 cnt=3840 ovr=0 busy=0",
                         i, mem_wr_en, sample_count, overrun, busy);
            end
        end
        tick(1, 0, 16'd0, 0);
        checks++;
        if (sample_count !== 12'd0 || busy !== 1'b1 || mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_start: got cnt=%0d busy=%b en=%b, expected cnt=0 busy=1 en=0",
                     sample_count, busy, mem_wr_en);
        end
        tick(0, 1, 16'hABCD, 0);
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wr_addr !== 16'd0 || mem_wr_data !== 30'h000ABCD0
            || sample_count !== 12'd0) begin
            errors++;
            $display("FAIL idle_first_write: got en=%b addr=%0d data=%0h cnt=%0d, expected en=1 addr=0 data=abcd0 cnt=0",
                     mem_wr_en, mem_wr_addr, mem_wr_data, sample_count);
        end
        tick(0, 0, 16'd0, 1);
        checks++;
        if (sample_count !== 12'd1 || mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_first_grant: got cnt=%0d en=%b, expected cnt=1 en=0", sample_count, mem_wr_en);
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(1, 0, 16'd0, 0);
        tick(0, 1, 16'hFFFF, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, i == 2, 16'h1234, 0);
            checks++;
            if (mem_wr_en !== 1'b1 || mem_wr_data !== 30'h000FFFF0 || mem_wr_addr !== 16'd0
                || overrun !== (i >= 2)) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got en=%b data=%0h addr=%0d ovr=%b, expected en=1 data=ffff0 addr=0 ovr=%0d",
                         i, mem_wr_en, mem_wr_data, mem_wr_addr, overrun, (i >= 2));
            end
        end
        tick(0, 0, 16'd0, 1);
        checks++;
        if (sample_count !== 12'd1 || mem_wr_en !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got cnt=%0d en=%b ovr=%b, expected cnt=1 en=0 ovr=1",
                     sample_count, mem_wr_en, overrun);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 16'd0, 1);
            checks++;
            if (mem_wr_en !== 1'b0 || sample_count !== 12'd1) begin
                errors++;
                $display("FAIL stall_dropped_write[%0d]: got en=%b cnt=%0d, expected en=0 cnt=1",
                         i, mem_wr_en, sample_count);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        do_reset();
        tick(1, 0, 16'd0, 0);
        for (int i = 0; i < 10; i++) begin
            v = 16'($urandom);
            tick(0, 1, v, 1);
            checks++;
            if (mem_wr_en !== 1'b1 || mem_wr_addr !== 16'(i) || mem_wr_data !== {10'd0, v, 4'd0}
                || sample_count !== 12'(i)) begin
                errors++;
                $display("FAIL b2b_write[%0d]: got en=%b addr=%0d data=%0h cnt=%0d, expected en=1 addr=%0d data=%0h cnt=%0d",
                         i, mem_wr_en, mem_wr_addr, mem_wr_data, sample_count, i, {10'd0, v, 4'd0}, i);
            end
        end
        tick(0, 0, 16'd0, 1);
        checks++;
        if (sample_count !== 12'd10 || overrun !== 1'b0 || mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: got cnt=%0d ovr=%b en=%b, expected cnt=10 ovr=0 en=0",
                     sample_count, overrun, mem_wr_en);
        end
    endtask

    task automatic test_reset_mid_epoch();
        bit saw_done = 0;
        do_reset();
        tick(1, 0, 16'd0, 0);
        for (int i = 0; i <= 100; i++) tick(0, 1, 16'($urandom), 1);
        checks++;
        if (sample_count !== 12'd100 || mem_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got cnt=%0d en=%b, expected cnt=100 en=1", sample_count, mem_wr_en);
        end
        rst = 1;
        #1;
        checks++;
        if (mem_wr_en !== 1'b0 || busy !== 1'b0 || sample_count !== 12'd0 || mem_wr_addr !== 16'd0) begin
            errors++;
            $display("FAIL midrst_async: got en=%b busy=%b cnt=%0d addr=%0d, expected 0 0 0 0",
                     mem_wr_en, busy, sample_count, mem_wr_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 if (done === 1'b1) saw_done = 1;
        end
        rst = 0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            tick(0, 0, 16'd0, 1);
            if (done === 1'b1) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL midrst_no_done: got done pulse=1, expected 0");
        end
        tick(1, 0, 16'd0, 0);
        tick(0, 1, 16'h0055, 0);
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wr_addr !== 16'd0 || mem_wr_data !== 30'h00000550) begin
            errors++;
            $display("FAIL midrst_restart: got en=%b addr=%0d data=%0h, expected en=1 addr=0 data=550",
                     mem_wr_en, mem_wr_addr, mem_wr_data);
        end
    endtask

    task automatic test_start_while_busy();
        int dones = 0;
        do_reset();
        tick(1, 0, 16'd0, 0);
        for (int k = 0; k < NUM; k++) begin
            tick(k == 50, 1, 16'(k), 1);
            if (done === 1'b1) dones++;
            checks++;
            if (mem_wr_en !== 1'b1 || mem_wr_addr !== 16'(k) || mem_wr_data !== (30'(k) << 4)
                || sample_count !== 12'(k) || busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_start_write[%0d]: got en=%b addr=%0d data=%0h cnt=%0d busy=%b, expected en=1 addr=%0d data=%0h cnt=%0d busy=1",
                         k, mem_wr_en, mem_wr_addr, mem_wr_data, sample_count, busy, k, 30'(k) << 4, k);
            end
        end
        tick(0, 0, 16'd0, 1);
        if (done === 1'b1) dones++;
        tick(0, 0, 16'd0, 0);
        if (done === 1'b1) dones++;
        checks++;
        if (dones != 1 || sample_count !== 12'd3840 || mem_wr_addr !== 16'd3839 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_done: got pulses=%0d cnt=%0d addr=%0d ovr=%b, expected 1 3840 3839 0",
                     dones, sample_count, mem_wr_addr, overrun);
        end
    endtask

    task automatic test_random();
        int  dones = 0;
        bit  finished = 0;
        do_reset();
        tick(1, 0, 16'd0, 0);
        for (int c = 0; c < 30000 && !finished; c++) begin
            tick(0, $urandom_range(0, 99) < 70, 16'($urandom), $urandom_range(0, 99) < 60);
            checks++;
            if (mem_wr_en !== m_pend || (m_pend && (mem_wr_addr !== 16'(m_addr) || mem_wr_data !== m_data))
                || sample_count !== 12'(m_cnt) || busy !== m_busy || done !== m_done || overrun !== m_ovr) begin
                errors++;
                $display("FAIL random[%0d]: got en=%b addr=%0d data=%0h cnt=%0d busy=%b done=%b ovr=%b, expected en=%b addr=%0d data=%0h cnt=%0d busy=%b done=%b ovr=%b",
                         c, mem_wr_en, mem_wr_addr, mem_wr_data, sample_count, busy, done, overrun,
                         m_pend, m_addr, m_data, m_cnt, m_busy, m_done, m_ovr);
            end
            if (done === 1'b1) begin
                dones++;
                finished = 1;
            end
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL random_timeout: got no done within 30000 cycles, expected done after %0d writes", NUM);
        end
        tick(0, 1, 16'd1, 1);
        if (done === 1'b1) dones++;
        checks++;
        if (dones != 1 || busy !== 1'b0 || mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL random_end: got pulses=%0d busy=%b en=%b, expected 1 0 0", dones, busy, mem_wr_en);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_epoch();
        test_idle_ignore();
        test_stall();
        test_back_to_back();
        test_reset_mid_epoch();
        test_start_while_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
